// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial subtractor: computes diff = a - b one bit per clock, LSB first,
// through a single full-subtractor cell with a registered borrow between steps.
module serial_subtractor_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_p,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic [CNT_W-1:0] cnt;
    logic             borrow_q;

    logic             x;
    logic             y;
    logic             d;
    logic             bout;
    logic [WIDTH-1:0] res_next;

    // One full-subtractor cell, shared by every bit position.
    assign x        = a_sr[0];
    assign y        = b_sr[0];
    assign d        = x ^ y ^ borrow_q;
    assign bout     = (~x & y) | (~(x ^ y) & borrow_q);
    assign res_next = {d, res_sr[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (reset_p) begin
            state      <= IDLE;
            ready      <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            diff       <= '0;
            borrow_out <= 1'b0;
            a_sr       <= '0;
            b_sr       <= '0;
            res_sr     <= '0;
            cnt        <= '0;
            borrow_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sr     <= a;
                        b_sr     <= b;
                        res_sr   <= '0;
                        cnt      <= '0;
                        borrow_q <= 1'b0;
                        state    <= RUN;
                        ready    <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                RUN: begin
                    a_sr     <= a_sr >> 1;
                    b_sr     <= b_sr >> 1;
                    res_sr   <= res_next;
                    borrow_q <= bout;
                    // Publish on the final bit so diff/borrow_out move only once per operation.
                    if (cnt == LAST_BIT) begin
                        state      <= DONE;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        diff       <= res_next;
                        borrow_out <= bout;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    ready <= 1'b1;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    ready <= 1'b1;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// Self-checking bench for serial_subtractor_ctrl (WIDTH=8): directed vectors,
// ignored start/operand changes, mid-run reset, back-to-back and random streams.
module tb_serial_subtractor_ctrl;

    localparam int WIDTH = 8;

    typedef struct {
        logic [WIDTH-1:0] diff;
        logic             borrow;
        int               acc_edge;
    } exp_t;

    logic             clk;
    logic             reset_p;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;

    serial_subtractor_ctrl #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .reset_p    (reset_p),
        .start      (start),
        .a          (a),
        .b          (b),
        .ready      (ready),
        .busy       (busy),
        .done       (done),
        .diff       (diff),
        .borrow_out (borrow_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge and settle just past it.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic launch(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv);
        exp_t e;
        a     = av;
        b     = bv;
        start = 1'b1;
        e.diff     = av - bv;
        e.borrow   = (av < bv);
        e.acc_edge = cyc + 1;
        sb.push_back(e);
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(output int cycles);
        cycles = 0;
        while (!done && cycles < WIDTH + 10) begin
            step();
            cycles++;
        end
    endtask

    task automatic test_reset();
        reset_p = 1'b1;
        step();
        step();
        reset_p = 1'b0;
        n_checks++; if (ready !== 1'b1) $display("[TB] FAIL reset_ready got=%b exp=1", ready); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy got=%b exp=0", busy); else n_pass++;
        n_checks++; if (done !== 1'b0) $display("[TB] FAIL reset_done got=%b exp=0", done); else n_pass++;
        n_checks++; if (diff !== 8'h00) $display("[TB] FAIL reset_diff got=%h exp=00", diff); else n_pass++;
        n_checks++; if (borrow_out !== 1'b0) $display("[TB] FAIL reset_borrow got=%b exp=0", borrow_out); else n_pass++;
    endtask

    task automatic test_directed();
        logic [WIDTH-1:0] va[5] = '{8'h05, 8'h03, 8'h00, 8'hFF, 8'h80};
        logic [WIDTH-1:0] vb[5] = '{8'h03, 8'h05, 8'h01, 8'hFF, 8'h7F};
        logic [WIDTH-1:0] rd[5] = '{8'h02, 8'hFE, 8'hFF, 8'h00, 8'h01};
        logic             rb[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        int               cycles;
        int               busy_cnt;
        exp_t             e;
        for (int i = 0; i < 5; i++) begin
            n_checks++; if (ready !== 1'b1) $display("[TB] FAIL dir%0d_ready_before got=%b exp=1", i, ready); else n_pass++;
            launch(va[i], vb[i]);
            busy_cnt = 0;
            cycles   = 0;
            while (!done && cycles < WIDTH + 10) begin
                if (busy === 1'b1) busy_cnt++;
                step();
                cycles++;
            end
            e = sb.pop_front();
            n_checks++; if (cycles !== WIDTH) $display("[TB] FAIL dir%0d_latency got=%0d exp=%0d", i, cycles, WIDTH); else n_pass++;
            n_checks++; if (busy_cnt !== WIDTH) $display("[TB] FAIL dir%0d_busy_cycles got=%0d exp=%0d", i, busy_cnt, WIDTH); else n_pass++;
            n_checks++; if (diff !== rd[i] || diff !== e.diff) $display("[TB] FAIL dir%0d_diff got=%h exp=%h", i, diff, rd[i]); else n_pass++;
            n_checks++; if (borrow_out !== rb[i]) $display("[TB] FAIL dir%0d_borrow got=%b exp=%b", i, borrow_out, rb[i]); else n_pass++;
            step();
            n_checks++; if (done !== 1'b0 || ready !== 1'b1) $display("[TB] FAIL dir%0d_after_done got done=%b ready=%b exp done=0 ready=1", i, done, ready); else n_pass++;
            n_checks++; if (diff !== rd[i]) $display("[TB] FAIL dir%0d_diff_held got=%h exp=%h", i, diff, rd[i]); else n_pass++;
        end
    endtask

    task automatic test_ignore_midrun();
        int   cycles;
        exp_t e;
        launch(8'h9C, 8'h3A);
        step();
        start = 1'b1;
        a     = 8'h11;
        b     = 8'h77;
        step();
        a     = 8'hEE;
        step();
        start = 1'b0;
        wait_done(cycles);
        e = sb.pop_front();
        n_checks++; if (cycles + 3 !== WIDTH) $display("[TB] FAIL ign_latency got=%0d exp=%0d", cycles + 3, WIDTH); else n_pass++;
        n_checks++; if (diff !== e.diff) $display("[TB] FAIL ign_diff got=%h exp=%h", diff, e.diff); else n_pass++;
        n_checks++; if (borrow_out !== e.borrow) $display("[TB] FAIL ign_borrow got=%b exp=%b", borrow_out, e.borrow); else n_pass++;
        // start raised during DONE must not launch a new operation.
        start = 1'b1;
        step();
        start = 1'b0;
        n_checks++; if (ready !== 1'b1) $display("[TB] FAIL ign_done_ready got=%b exp=1", ready); else n_pass++;
        step();
        n_checks++; if (busy !== 1'b0 || ready !== 1'b1) $display("[TB] FAIL ign_done_start got busy=%b ready=%b exp busy=0 ready=1", busy, ready); else n_pass++;
        n_checks++; if (diff !== 8'h62) $display("[TB] FAIL ign_diff_held got=%h exp=62", diff); else n_pass++;
    endtask

    task automatic test_reset_midrun();
        int seen_done = 0;
        launch(8'h44, 8'h12);
        step();
        step();
        step();
        reset_p = 1'b1;
        step();
        reset_p = 1'b0;
        sb.delete();
        n_checks++; if (ready !== 1'b1 || busy !== 1'b0) $display("[TB] FAIL rst_mid_state got ready=%b busy=%b exp ready=1 busy=0", ready, busy); else n_pass++;
        n_checks++; if (diff !== 8'h00) $display("[TB] FAIL rst_mid_diff got=%h exp=00", diff); else n_pass++;
        n_checks++; if (borrow_out !== 1'b0) $display("[TB] FAIL rst_mid_borrow got=%b exp=0", borrow_out); else n_pass++;
        for (int i = 0; i < WIDTH + 4; i++) begin
            if (done === 1'b1) seen_done++;
            step();
        end
        n_checks++; if (seen_done !== 0) $display("[TB] FAIL rst_mid_no_done got=%0d pulses exp=0", seen_done); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int   got   = 0;
        int   guard = 0;
        bit   accept;
        exp_t e;
        start = 1'b1;
        a     = 8'($urandom());
        b     = 8'($urandom());
        while (got < 4 && guard < 100) begin
            accept = (ready === 1'b1) && start;
            if (accept) begin
                e.diff     = a - b;
                e.borrow   = (a < b);
                e.acc_edge = cyc + 1;
                sb.push_back(e);
            end
            step();
            guard++;
            a = 8'($urandom());
            b = 8'($urandom());
            if (done === 1'b1) begin
                n_checks++;
                if (sb.size() == 0) begin
                    $display("[TB] FAIL b2b_unexpected_done got=done exp=no_done");
                end else begin
                    n_pass++;
                    e = sb.pop_front();
                    got++;
                    n_checks++; if (diff !== e.diff) $display("[TB] FAIL b2b_diff got=%h exp=%h", diff, e.diff); else n_pass++;
                    n_checks++; if (borrow_out !== e.borrow) $display("[TB] FAIL b2b_borrow got=%b exp=%b", borrow_out, e.borrow); else n_pass++;
                    n_checks++; if (cyc - e.acc_edge !== WIDTH) $display("[TB] FAIL b2b_latency got=%0d exp=%0d", cyc - e.acc_edge, WIDTH); else n_pass++;
                end
            end
        end
        start = 1'b0;
        if (got < 4) begin
            n_checks++;
            $display("[TB] FAIL b2b_timeout got=%0d ops exp=4", got);
        end
        step();
        step();
        sb.delete();
    endtask

    task automatic test_random();
        int   got   = 0;
        int   guard = 0;
        bit   accept;
        exp_t e;
        while (got < 1000 && guard < 40000) begin
            accept = (ready === 1'b1) && start;
            if (accept) begin
                e.diff     = a - b;
                e.borrow   = (a < b);
                e.acc_edge = cyc + 1;
                sb.push_back(e);
            end
            step();
            guard++;
            a     = 8'($urandom());
            b     = 8'($urandom());
            start = 1'($urandom_range(0, 1));
            if (done === 1'b1) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    $display("[TB] FAIL rnd_unexpected_done got=done exp=no_done");
                end else begin
                    e = sb.pop_front();
                    got++;
                    n_checks++; if (diff !== e.diff) $display("[TB] FAIL rnd_diff got=%h exp=%h", diff, e.diff); else n_pass++;
                    n_checks++; if (borrow_out !== e.borrow) $display("[TB] FAIL rnd_borrow got=%b exp=%b", borrow_out, e.borrow); else n_pass++;
                    n_checks++; if (cyc - e.acc_edge !== WIDTH) $display("[TB] FAIL rnd_latency got=%0d exp=%0d", cyc - e.acc_edge, WIDTH); else n_pass++;
                end
            end
        end
        start = 1'b0;
        if (got < 1000) begin
            n_checks++;
            $display("[TB] FAIL rnd_timeout got=%0d ops exp=1000", got);
        end
    endtask

    initial begin
        reset_p = 1'b1;
        start   = 1'b0;
        a       = '0;
        b       = '0;
        test_reset();
        test_directed();
        test_ignore_midrun();
        test_reset_midrun();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
